// File: rtl/parking_pkg.sv
// Shared types and constants for the parking gate front end.
package parking_pkg;

  localparam int SPOT_W         = 2;
  localparam int NUM_SPOTS      = 4;
  localparam int OP_TIMEOUT_DEF = 16;

  // The wait counter only has to count 0 .. op_timeout-1.
  function automatic int timeout_w(input int op_timeout);
    return (op_timeout < 2) ? 1 : $clog2(op_timeout);
  endfunction

  localparam int TIMEOUT_W = timeout_w(OP_TIMEOUT_DEF);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    ENTRY_PULSE = 3'd1,
    ENTRY_WAIT  = 3'd2,
    EXIT_PULSE  = 3'd3,
    EXIT_WAIT   = 3'd4
  } gate_state_t;

  typedef struct packed {
    gate_state_t state;
    logic        arrive_level;
    logic        arrive_pending;
  } gate_debug_t;

endpackage

// File: rtl/parking_debounce.sv
// Level debouncer: a change is accepted after DEBOUNCE_CYCLES consecutive
// samples that differ from the accepted level; rise pulses on an accepted 0->1.
module parking_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);
  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);

  logic [CW-1:0] cnt;
  logic          level_q;
  logic          rise_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      if (raw != level_q) begin
        if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          level_q <= raw;
          rise_q  <= raw;
          cnt     <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        // any sample matching the accepted level restarts the count
        cnt <= '0;
      end
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/parking_gate_sequencer.sv
// Turns gate events into single-cycle entry/exit sensor pulses for the parking
// manager, captures the allocated spot and confirms completion via parking_spots.
module parking_gate_sequencer
  import parking_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int OP_TIMEOUT      = OP_TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 arrive_raw,
  input  logic                 leave_req,
  input  logic [SPOT_W-1:0]    leave_ticket,
  input  logic [SPOT_W-1:0]    best_position,
  input  logic                 full_led,
  input  logic [NUM_SPOTS-1:0] parking_spots,
  output logic                 entry_sensor,
  output logic                 exit_sensor,
  output logic [SPOT_W-1:0]    exiting_position,
  output logic                 ticket_valid,
  output logic [SPOT_W-1:0]    ticket_spot,
  output logic                 leave_ack,
  output logic                 leave_err,
  output logic                 entry_rejected,
  output logic                 arrival_drop,
  output logic                 timeout_err,
  output gate_debug_t          debug
);
  localparam int CNT_W = timeout_w(OP_TIMEOUT);

  gate_state_t       state, state_next;
  logic              arrive_level, arrive_rise, arrive_pending;
  logic [SPOT_W-1:0] exit_pos, ticket_pos;
  logic [CNT_W-1:0]  wait_cnt;
  logic              leave_occupied, entry_done, exit_done, timed_out;
  logic              exit_start, consume;

  parking_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_arrive_debounce (
    .clk   (clk),
    .reset (reset),
    .raw   (arrive_raw),
    .level (arrive_level),
    .rise  (arrive_rise)
  );

  // Exit wins over a pending arrival; an arrival is consumed only when no leave is requested.
  assign leave_occupied = parking_spots[leave_ticket];
  assign entry_done     = parking_spots[ticket_pos];
  assign exit_done      = !parking_spots[exit_pos];
  assign timed_out      = (wait_cnt == CNT_W'(OP_TIMEOUT - 1));
  assign exit_start     = (state == IDLE) && leave_req && leave_occupied;
  assign consume        = (state == IDLE) && !leave_req && arrive_pending;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      arrive_pending <= 1'b0;
      exit_pos       <= '0;
      ticket_pos     <= '0;
      wait_cnt       <= '0;
    end else begin
      state          <= state_next;
      arrive_pending <= (arrive_pending && !consume) || arrive_rise;
      if (exit_start) begin
        exit_pos <= leave_ticket;
      end else if (state_next == IDLE) begin
        exit_pos <= '0;
      end
      if (consume && !full_led) begin
        ticket_pos <= best_position;
      end
      if (state == ENTRY_WAIT || state == EXIT_WAIT) begin
        wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (exit_start) begin
          state_next = EXIT_PULSE;
        end else if (consume && !full_led) begin
          state_next = ENTRY_PULSE;
        end
      end
      ENTRY_PULSE: state_next = ENTRY_WAIT;
      ENTRY_WAIT:  if (entry_done || timed_out) state_next = IDLE;
      EXIT_PULSE:  state_next = EXIT_WAIT;
      EXIT_WAIT:   if (exit_done || timed_out) state_next = IDLE;
      default:     state_next = IDLE;
    endcase
  end

  always_comb begin
    entry_sensor     = 1'b0;
    exit_sensor      = 1'b0;
    exiting_position = '0;
    ticket_valid     = 1'b0;
    ticket_spot      = '0;
    leave_ack        = 1'b0;
    leave_err        = 1'b0;
    entry_rejected   = 1'b0;
    arrival_drop     = 1'b0;
    timeout_err      = 1'b0;
    if (!reset) begin
      entry_sensor     = (state == ENTRY_PULSE);
      exit_sensor      = (state == EXIT_PULSE);
      exiting_position = exit_pos;
      ticket_spot      = ticket_pos;
      ticket_valid     = (state == ENTRY_WAIT) && entry_done;
      leave_err        = (state == IDLE) && leave_req && !leave_occupied;
      leave_ack        = leave_err || ((state == EXIT_WAIT) && exit_done);
      entry_rejected   = consume && full_led;
      arrival_drop     = arrive_rise && arrive_pending && !consume;
      timeout_err      = timed_out && (((state == ENTRY_WAIT) && !entry_done) ||
                                       ((state == EXIT_WAIT) && !exit_done));
    end
  end

  assign debug = '{state: state, arrive_level: arrive_level, arrive_pending: arrive_pending};

endmodule

// File: tb/tb_parking_gate_sequencer.sv
// Randomized transaction bench for parking_gate_sequencer: the bench plays the
// gate hardware and the manager, and predicts every output pulse with its cycle.
module tb_parking_gate_sequencer;
  import parking_pkg::*;

  localparam int K_ENTRY = 1, K_EXIT = 2, K_TICKET = 3, K_ACK = 4;
  localparam int K_REJ = 5, K_DROP = 6, K_TMO = 7;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        arrive_raw = 1'b0;
  logic        leave_req = 1'b0;
  logic [1:0]  leave_ticket = '0;
  logic [1:0]  best_position = '0;
  logic [3:0]  parking_spots = '0;
  logic        full_led;
  logic        entry_sensor, exit_sensor, ticket_valid;
  logic        leave_ack, leave_err, entry_rejected, arrival_drop, timeout_err;
  logic [1:0]  exiting_position, ticket_spot;
  gate_debug_t debug;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [23:0] exp_q[$];

  assign full_led = &parking_spots;

  parking_gate_sequencer #(.DEBOUNCE_CYCLES(4), .OP_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .arrive_raw(arrive_raw), .leave_req(leave_req),
    .leave_ticket(leave_ticket), .best_position(best_position), .full_led(full_led),
    .parking_spots(parking_spots), .entry_sensor(entry_sensor), .exit_sensor(exit_sensor),
    .exiting_position(exiting_position), .ticket_valid(ticket_valid), .ticket_spot(ticket_spot),
    .leave_ack(leave_ack), .leave_err(leave_err), .entry_rejected(entry_rejected),
    .arrival_drop(arrival_drop), .timeout_err(timeout_err), .debug(debug)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic logic [23:0] mk(input int cy, input int kind, input int data);
    return {16'(cy), 4'(kind), 4'(data)};
  endfunction

  // Expected events are kept ordered by (cycle, kind) so push order is free.
  function automatic void push(input logic [23:0] w);
    int i = 0;
    while (i < exp_q.size() && exp_q[i] < w) i++;
    exp_q.insert(i, w);
  endfunction

  function automatic int pick(input logic [3:0] m, input bit occ);
    int cand[$];
    for (int i = 0; i < 4; i++) if (m[i] == occ) cand.push_back(i);
    if (cand.size() == 0) return -1;
    return cand[$urandom_range(0, cand.size() - 1)];
  endfunction

  function automatic logic [31:0] outs_vec();
    return 32'({entry_sensor, exit_sensor, exiting_position, ticket_valid, ticket_spot,
                leave_ack, leave_err, entry_rejected, arrival_drop, timeout_err});
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h required %0h", name, cyc, act, req);
    end
  endtask

  // scoreboard: monitor pops one expected event per observed pulse
  task automatic see(input string name, input logic [23:0] w);
    logic [23:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s unexpected: got cycle %0d kind %0d data %0d, none required",
               name, w[23:8], w[7:4], w[3:0]);
    end else begin
      e = exp_q.pop_front();
      if (e !== w) begin
        errors++;
        $display("FAIL %s: got cycle %0d kind %0d data %0d required cycle %0d kind %0d data %0d",
                 name, w[23:8], w[7:4], w[3:0], e[23:8], e[7:4], e[3:0]);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (entry_sensor || exit_sensor) begin
        checks++;
        if (entry_sensor && exit_sensor) begin
          errors++;
          $display("FAIL sensor_overlap at cycle %0d: got both 1 required at most one", cyc);
        end
      end
      if (leave_err && !leave_ack) begin
        checks++;
        errors++;
        $display("FAIL leave_err_alone at cycle %0d: got leave_ack 0 required 1", cyc);
      end
      if (entry_sensor)   see("entry_sensor", mk(cyc, K_ENTRY, 0));
      if (exit_sensor)    see("exit_sensor", mk(cyc, K_EXIT, exiting_position));
      if (ticket_valid)   see("ticket_valid", mk(cyc, K_TICKET, ticket_spot));
      if (leave_ack)      see("leave_ack", mk(cyc, K_ACK, leave_err));
      if (entry_rejected) see("entry_rejected", mk(cyc, K_REJ, 0));
      if (arrival_drop)   see("arrival_drop", mk(cyc, K_DROP, 0));
      if (timeout_err)    see("timeout_err", mk(cyc, K_TMO, 0));
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing: got %0d events outstanding required 0, first cycle %0d kind %0d",
               name, exp_q.size(), exp_q[0][23:8], exp_q[0][7:4]);
      exp_q.delete();
    end
  endtask

  function automatic int rnd_d();
    int v;
    v = $urandom_range(1, 20);
    return (v > 16) ? 0 : v;
  endfunction

  // Arrival: accepted 4 samples after raw rises, entry pulse 2 cycles later.
  // d = cycles after the pulse at which the manager shows the spot (0 = never).
  task automatic do_entry(input int bp_req, input int d);
    int c, h, bp, len;
    bit full;
    c = cyc;
    h = $urandom_range(4, 6);
    full = &parking_spots;
    bp = bp_req;
    if (bp < 0) bp = full ? int'($urandom_range(0, 3)) : pick(parking_spots, 1'b0);
    if (full) begin
      push(mk(c + 5, K_REJ, 0));
      len = 12;
    end else begin
      push(mk(c + 6, K_ENTRY, 0));
      if (d > 0) begin
        push(mk(c + 6 + d, K_TICKET, bp));
        len = 8 + d;
      end else begin
        push(mk(c + 22, K_TMO, 0));
        len = 24;
      end
    end
    if (len < h + 6) len = h + 6;
    best_position = 2'(bp);
    for (int k = 0; k < len; k++) begin
      arrive_raw = (k < h);
      if (!full && d > 0 && k == 6 + d) parking_spots[bp] = 1'b1;
      if (full && k == 6) chk("rejected_stays_idle", 32'(debug.state), 32'(IDLE));
      tick();
    end
    idle(2);
    drained("entry");
    if (!full && d > 0) chk("ticket_spot_held", 32'(ticket_spot), 32'(bp));
  endtask

  // Leave request: error ack at once if the spot is empty, else exit pulse next cycle.
  // d = 0 lets the manager stall so the request times out and is retried.
  task automatic do_exit(input int t, input int d);
    int c, clr, drop_k;
    c = cyc;
    leave_ticket = 2'(t);
    clr = -1;
    if (!parking_spots[t]) begin
      push(mk(c, K_ACK, 1));
      drop_k = 1;
    end else if (d > 0) begin
      push(mk(c + 1, K_EXIT, t));
      push(mk(c + 1 + d, K_ACK, 0));
      clr = 1 + d;
      drop_k = 2 + d;
    end else begin
      push(mk(c + 1, K_EXIT, t));
      push(mk(c + 17, K_TMO, 0));
      push(mk(c + 19, K_EXIT, t));
      push(mk(c + 20, K_ACK, 0));
      clr = 20;
      drop_k = 21;
    end
    for (int k = 0; k <= drop_k; k++) begin
      leave_req = (k < drop_k);
      if (k == clr) parking_spots[t] = 1'b0;
      tick();
    end
    idle(2);
    drained("exit");
    chk("exiting_position_idle", 32'(exiting_position), 32'd0);
  endtask

  // Leave request arrives in the same cycle an arrival becomes pending.
  task automatic do_priority(input int t, input int bp, input int d, input int e);
    int c;
    c = cyc;
    leave_ticket = 2'(t);
    best_position = 2'(bp);
    push(mk(c + 6, K_EXIT, t));
    push(mk(c + 6 + d, K_ACK, 0));
    push(mk(c + 8 + d, K_ENTRY, 0));
    push(mk(c + 8 + d + e, K_TICKET, bp));
    for (int k = 0; k <= 9 + d + e; k++) begin
      arrive_raw = (k < 4);
      leave_req = (k >= 5) && (k < 7 + d);
      if (k == 6 + d) parking_spots[t] = 1'b0;
      if (k == 8 + d + e) parking_spots[bp] = 1'b1;
      tick();
    end
    idle(2);
    drained("priority");
  endtask

  // Two arrivals during a long exit: the first waits, the second is dropped.
  task automatic do_busy(input int t, input int bp, input int d, input int e);
    int c;
    c = cyc;
    leave_ticket = 2'(t);
    best_position = 2'(bp);
    push(mk(c + 1, K_EXIT, t));
    push(mk(c + 12, K_DROP, 0));
    push(mk(c + 1 + d, K_ACK, 0));
    push(mk(c + 3 + d, K_ENTRY, 0));
    push(mk(c + 3 + d + e, K_TICKET, bp));
    for (int k = 0; k <= 4 + d + e; k++) begin
      arrive_raw = (k < 4) || (k >= 8 && k < 12);
      leave_req = (k < 2 + d);
      if (k == 1 + d) parking_spots[t] = 1'b0;
      if (k == 3 + d + e) parking_spots[bp] = 1'b1;
      tick();
    end
    idle(2);
    drained("busy");
  endtask

  task automatic do_glitch();
    for (int k = 0; k < 14; k++) begin
      arrive_raw = (k < 6) && (k % 2 == 0);
      tick();
    end
    drained("glitch");
    chk("glitch_pending", 32'(debug.arrive_pending), 32'd0);
    chk("glitch_level", 32'(debug.arrive_level), 32'd0);
  endtask

  task automatic do_abort();
    int c, bp;
    c = cyc;
    bp = pick(parking_spots, 1'b0);
    best_position = 2'(bp);
    push(mk(c + 6, K_ENTRY, 0));
    for (int k = 0; k < 11; k++) begin
      arrive_raw = (k < 4);
      tick();
    end
    reset = 1'b1;
    #2;
    chk("abort_outputs", outs_vec(), 32'd0);
    chk("abort_state", 32'(debug.state), 32'(IDLE));
    tick();
    reset = 1'b0;
    idle(3);
    drained("abort");
    chk("abort_ticket_spot", 32'(ticket_spot), 32'd0);
  endtask

  initial begin
    idle(3);
    chk("reset_outputs", outs_vec(), 32'd0);
    chk("reset_state", 32'(debug.state), 32'(IDLE));
    reset = 1'b0;
    idle(2);

    do_entry(2, 3);
    do_glitch();
    parking_spots = 4'b1111;
    do_entry(-1, 1);
    parking_spots = 4'b0011;
    do_priority(1, 2, 3, 2);
    parking_spots = 4'b0001;
    do_exit(3, 4);
    do_entry(-1, 0);
    do_abort();

    for (int n = 0; n < 40; n++) begin
      int sel, t, bp;
      sel = $urandom_range(0, 4);
      t = pick(parking_spots, 1'b1);
      case (sel)
        0: do_entry(-1, rnd_d());
        1: do_exit($urandom_range(0, 3), rnd_d());
        2, 3: begin
          if (t >= 0) begin
            bp = pick(parking_spots & ~4'(1 << t), 1'b0);
            if (sel == 2) do_priority(t, bp, $urandom_range(1, 16), $urandom_range(1, 16));
            else do_busy(t, bp, $urandom_range(12, 16), $urandom_range(1, 16));
          end else begin
            do_entry(-1, $urandom_range(1, 16));
          end
        end
        default: do_glitch();
      endcase
    end

    idle(2);
    drained("final");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/parking_gate_sequencer.md
Name: parking_gate_sequencer

Overview:
Driver-side front end for parking_system_managment. It converts raw gate events into the manager's sensor protocol: a debounced arrival loop and a pay-station leave request become single-cycle entry_sensor/exit_sensor pulses with exiting_position. It captures the spot the manager allocates, reports it as a ticket, and confirms completion by watching parking_spots. It sits between the gate hardware and the manager.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable cycles required on arrive_raw before a level change is accepted (min 1)
OP_TIMEOUT, 16, cycles allowed in a WAIT state before timeout_err

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
arrive_raw  input  1  raw car-present loop at the entry gate
leave_req  input  1  exit request level from the pay station; held until leave_ack
leave_ticket  input  2  spot index printed on the departing car's ticket
best_position  input  2  manager's next free spot
full_led  input  1  manager's full indication
parking_spots  input  4  manager occupancy map; bit i = spot i occupied
entry_sensor  output  1  one-cycle entry pulse to the manager
exit_sensor  output  1  one-cycle exit pulse to the manager
exiting_position  output  2  spot being vacated
ticket_valid  output  1  one-cycle pulse: entry completed
ticket_spot  output  2  allocated spot; valid with ticket_valid, held afterwards
leave_ack  output  1  one-cycle pulse: leave request consumed (success or error)
leave_err  output  1  one-cycle pulse with leave_ack: ticket spot was not occupied
entry_rejected  output  1  one-cycle pulse: arrival refused because the lot is full
arrival_drop  output  1  one-cycle pulse: arrival lost because one is already pending
timeout_err  output  1  one-cycle pulse: manager did not update parking_spots within OP_TIMEOUT

Behaviour:
- Reset value: all outputs 0. State is IDLE. Pending flag, debounce counter and timeout counter are cleared. Reset asserted mid-operation aborts the operation with no completion pulse.
- Debounce: accepted level changes only after arrive_raw differs from the accepted level for DEBOUNCE_CYCLES consecutive cycles. Any glitch restarts the count. A 0->1 accepted change sets arrive_pending. The next arrival requires an accepted 1->0 change first.
- Arrival accepted while arrive_pending=1: pulse arrival_drop; pending stays set.
- FSM states: IDLE, ENTRY_PULSE, ENTRY_WAIT, EXIT_PULSE, EXIT_WAIT.
- Decision rules in IDLE. Exit has priority over entry when both are pending.
  - leave_req=1 and parking_spots[leave_ticket]=0: pulse leave_ack and leave_err together; stay in IDLE.
  - leave_req=1 and the spot is occupied: latch leave_ticket into exiting_position and go to EXIT_PULSE.
  - Otherwise, if arrive_pending=1 and full_led=1: pulse entry_rejected, clear pending, stay in IDLE.
  - Otherwise, if arrive_pending=1: latch best_position into ticket_spot, clear pending, go to ENTRY_PULSE.
- ENTRY_PULSE: entry_sensor=1 for exactly one cycle, then ENTRY_WAIT.
- ENTRY_WAIT: when parking_spots[ticket_spot]=1, pulse ticket_valid and go to IDLE.
- EXIT_PULSE: exit_sensor=1 for one cycle. exiting_position holds the latched value from EXIT_PULSE through EXIT_WAIT and returns to 0 in IDLE.
- EXIT_WAIT: when parking_spots[exiting_position]=0, pulse leave_ack and go to IDLE.
- Timeout: the counter clears on entry to each WAIT state and increments every WAIT cycle. When the counter reaches OP_TIMEOUT with no completion, pulse timeout_err and go to IDLE. A timed-out entry produces no ticket_valid. A timed-out exit produces no leave_ack, so the request retries while leave_req stays high.
- entry_sensor and exit_sensor are never both 1. At most one operation is in flight.
- Latency: from the arrival acceptance cycle, entry_sensor rises 2 cycles later (IDLE, then ENTRY_PULSE). From leave_req sampled in IDLE, exit_sensor rises 1 cycle later.
- Arrivals continue to be debounced and made pending during WAIT states.

Decomposition:
- parking_pkg holds:
  - SPOT_W=2 and NUM_SPOTS=4
  - the gate_state_t enum (IDLE, ENTRY_PULSE, ENTRY_WAIT, EXIT_PULSE, EXIT_WAIT)
  - a TIMEOUT_W width constant derived from OP_TIMEOUT
- One sub-module, parking_debounce: parameter DEBOUNCE_CYCLES; ports clk, reset, raw in, level out, rise pulse out. It is reusable for a future exit loop.

Test Plan:
- Reset, then arrive_raw high for 4 cycles with best_position=2, full_led=0. Required: entry_sensor pulses 2 cycles after acceptance. Model sets parking_spots=0100, then ticket_valid pulses with ticket_spot=2.
- arrive_raw toggles 1-0-1 with 1-cycle highs, DEBOUNCE_CYCLES=4. Required: no entry_sensor, no arrival_drop.
- parking_spots=1111, full_led=1, clean arrival. Required: entry_rejected pulses once; entry_sensor stays 0; FSM stays in IDLE.
- Spots 0011, leave_req=1 with leave_ticket=1, and an arrival pending in the same cycle. Required: exit served first, exit_sensor=1 with exiting_position=1. Model clears bit 1, then leave_ack pulses. The pending entry follows with entry_sensor.
- leave_req with leave_ticket=3 while parking_spots=0001. Required: leave_ack and leave_err pulse in the same cycle; exit_sensor stays 0.
- Entry issued, model never sets the spot bit. Required: timeout_err pulses exactly OP_TIMEOUT=16 cycles into ENTRY_WAIT; no ticket_valid. A reset asserted mid-wait clears all outputs immediately.
